backdoor_access_engine: RTL and testbench
=========================================

# backdoor_access_engine

Parametrised backdoor access engine for the CEP cosim testbench. It accepts 64-bit read/write requests from the DPI/system-driver thread over a valid/ready port and routes each one to one of `NUM_TARGETS` memory backdoor ports, selected by a programmable select register. Narrow (byte-wide) targets are served by serialising the request into 8 little-endian byte beats. It replaces the single-bit main-memory/SD-flash backdoor select with an N-way, width-aware, stall-aware sequencer that returns an explicit response.

## Interface
Parameters:
- `NUM_TARGETS`, 2: number of backdoor targets (1..16).
- `ADDR_W`, 32: request/target address width.
- `NARROW_MASK`, 'b10: bit i set means target i is byte-wide (8 beats); clear means 64-bit wide (1 beat).
- `RD_LAT`, 1: target read latency in cycles from the enable beat to valid `tgt_rdata` (1..7).
- `TGT_W`, $clog2(NUM_TARGETS) (min 1): width of the select register.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sel_set` in 1: one-cycle pulse that loads `sel_value` into the select register.
- `sel_value` in TGT_W: new target select.
- `sel_q` out TGT_W: current select register.
- `req_valid` in 1: request valid.
- `req_ready` out 1: engine can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 64: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 64: read data (0 for writes/errors).
- `rsp_err` out 1: select register was out of range.
- `tgt_en` out NUM_TARGETS: one-hot beat strobe.
- `tgt_we` out 1: beat is a write.
- `tgt_addr` out ADDR_W: beat address.
- `tgt_wdata` out 64: beat data; narrow beats use [7:0] only.
- `tgt_rdata` in NUM_TARGETS*64: flattened read data; target i is on [i*64 +: 64].
- `tgt_busy` in NUM_TARGETS: target i is unavailable (in reset or busy); beats to it stall.

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP.
- `req_ready` = (state==IDLE). The engine accepts a request on `req_valid & req_ready` and latches write, addr, wdata, sel_q, and the target's narrow bit.
- Out of range (latched sel ≥ NUM_TARGETS): IDLE→RESP with `rsp_err=1`, `rsp_rdata=0`. No `tgt_en` is driven.
- ISSUE:
  - If `tgt_busy[sel]`, hold with `tgt_en=0`. There is no timeout.
  - Otherwise assert `tgt_en[sel]` for exactly one cycle, with these beat fields:
    - Wide target: `tgt_addr = addr>>3`, `tgt_wdata = wdata`.
    - Narrow target: beat k (0..7) has `tgt_addr = addr+k` (mod 2^ADDR_W) and `tgt_wdata[7:0] = wdata[8k +: 8]`.
  - Writes: go to the next ISSUE beat, or to RESP after the last beat.
  - Reads: go to WAIT_RD.
- WAIT_RD:
  - Counts RD_LAT cycles, then captures the beat. Wide: the full word. Narrow: byte k into `rdata[8k +: 8]` from `tgt_rdata[sel*64 +: 8]`.
  - Then goes to ISSUE (next beat) or to RESP.
- Beat counter: 3 bits. The last beat is k==0 for wide targets and k==7 for narrow targets.
- RESP: `rsp_valid` holds until `rsp_ready`, then →IDLE.
- `sel_set` takes effect on the next clock edge in any state. An in-flight request keeps its latched select. The first request after `sel_set` sees the new value if its accept edge is later than the set edge.
- Address bits [2:0] are ignored by wide targets.

## Timing
- Reset (asynchronous) values: state IDLE, `sel_q=0`, `req_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `tgt_en=0`, `tgt_we=0`, `tgt_addr=0`, `tgt_wdata=0`.
- Reset mid-operation aborts the transaction with no response. `tgt_en` drops immediately.
- All outputs are registered.
- Latencies, with the accept edge at cycle 0 and no busy stalls:
  - Wide write: `tgt_en` in cycle 1, `rsp_valid` in cycle 2.
  - Narrow write: `tgt_en` in cycles 1..8, `rsp_valid` in cycle 9.
  - Wide read: `tgt_en` in cycle 1, capture at the end of cycle 1+RD_LAT, `rsp_valid` in cycle 2+RD_LAT.
  - Narrow read: beat k issues in cycle 1+k*(1+RD_LAT), `rsp_valid` in cycle 1+8*(1+RD_LAT).
  - Error: `rsp_valid` in cycle 1.
- Each busy cycle at an ISSUE step adds one cycle.
- Back-to-back: the next accept is possible in the cycle after `rsp_valid & rsp_ready`.

## Test plan
- Wide write then read: sel=0, write 0x0123456789ABCDEF to addr 0x1000, then read it back. Required: `tgt_addr=0x200`, a single `tgt_en[0]` pulse, `rsp_rdata=0x0123456789ABCDEF`, `rsp_valid` at cycle 2 (write) and cycle 3 (read, RD_LAT=1).
- Narrow write: sel=1, write 0x1122334455667788 to addr 0x40. Required: 8 beats at addr 0x40..0x47 with data 0x88,0x77,…,0x11, `rsp_valid` at cycle 9. A read-back returns the same word at cycle 17.
- Busy stall: hold `tgt_busy[1]` high for 5 cycles before beat 3 of a narrow write. Required: no `tgt_en` during the stall, correct beat order, `rsp_valid` at cycle 14.
- Out-of-range select: NUM_TARGETS=3, sel_set with value 3, then a read. Required: `rsp_err=1`, `rsp_rdata=0`, `tgt_en` never asserted, `rsp_valid` at cycle 1.
- Select change mid-flight: `sel_set`=0 during a narrow read on target 1. Required: all 8 beats go to target 1, and the next request goes to target 0.
- Reset abort: assert `rst` during beat 4 of a narrow write. Required: `tgt_en=0`, `rsp_valid=0`, `sel_q=0` immediately. After release, `req_ready=1` and a new request completes normally.

Source files
------------

// File: rtl/backdoor_access_engine.sv
// Backdoor access engine: routes 64-bit read/write requests to one of
// NUM_TARGETS memory backdoor ports. Byte-wide targets are served as eight
// little-endian byte beats. Stalls while the target reports busy.
module backdoor_access_engine #(
  parameter int unsigned                  NUM_TARGETS = 2,
  parameter int unsigned                  ADDR_W      = 32,
  parameter logic [NUM_TARGETS-1:0]       NARROW_MASK = 'b10,
  parameter int unsigned                  RD_LAT      = 1,
  parameter int unsigned                  TGT_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel_set,
  input  logic [TGT_W-1:0]              sel_value,
  output logic [TGT_W-1:0]              sel_q,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [63:0]                   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [63:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_TARGETS-1:0]        tgt_en,
  output logic                          tgt_we,
  output logic [ADDR_W-1:0]             tgt_addr,
  output logic [63:0]                   tgt_wdata,
  input  logic [NUM_TARGETS*64-1:0]     tgt_rdata,
  input  logic [NUM_TARGETS-1:0]        tgt_busy
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [TGT_W-1:0]         sel_d;
  logic [TGT_W-1:0]         req_sel_q, req_sel_d;
  logic                     write_q, write_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     narrow_q, narrow_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     req_ready_q, req_ready_d;
  logic [NUM_TARGETS-1:0]   tgt_en_q, tgt_en_d;
  logic                     tgt_we_q, tgt_we_d;
  logic [ADDR_W-1:0]        tgt_addr_q, tgt_addr_d;
  logic [DATA_W-1:0]        tgt_wdata_q, tgt_wdata_d;

  logic                     last_beat;
  logic                     sel_in_range;
  logic                     sel_narrow;
  logic [DATA_W-1:0]        rd_word;
  logic [NUM_TARGETS-1:0]   en_onehot;
  logic                     sel_busy;
  logic                     issue;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_set ? sel_value : sel_q;
    req_sel_d   = req_sel_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    narrow_d    = narrow_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;

    last_beat    = narrow_q ? (beat_q == 3'd7) : (beat_q == 3'd0);
    sel_in_range = ({1'b0, sel_q} < (TGT_W+1)'(NUM_TARGETS));

    sel_narrow = 1'b0;
    rd_word    = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (sel_q == TGT_W'(i))     sel_narrow = NARROW_MASK[i];
      if (req_sel_q == TGT_W'(i)) rd_word    = tgt_rdata[i*DATA_W +: DATA_W];
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          req_sel_d = sel_q;
          beat_d    = '0;
          rdata_d   = '0;
          if (sel_in_range) begin
            err_d    = 1'b0;
            narrow_d = sel_narrow;
            state_d  = S_ISSUE;
          end else begin
            err_d    = 1'b1;
            narrow_d = 1'b0;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        // A beat is on the port this cycle only when tgt_en_q is set
        if (|tgt_en_q) begin
          if (write_q) begin
            if (last_beat) state_d = S_RESP;
            else           beat_d  = beat_q + 3'd1;
          end else begin
            state_d = S_WAIT_RD;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      S_WAIT_RD: begin
        if (cnt_q == '0) begin
          if (narrow_q) rdata_d[{beat_q, 3'b000} +: 8] = rd_word[7:0];
          else          rdata_d = rd_word;
          if (last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Beat strobe for the next cycle, gated by the target's busy flag
    en_onehot = '0;
    sel_busy  = 1'b0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (req_sel_d == TGT_W'(i)) begin
        en_onehot[i] = 1'b1;
        sel_busy     = tgt_busy[i];
      end
    end
    issue    = (state_d == S_ISSUE) && !sel_busy;
    tgt_en_d = issue ? en_onehot : '0;
    tgt_we_d = issue & write_d;
    if (issue) begin
      tgt_addr_d  = narrow_d ? (addr_d + ADDR_W'(beat_d)) : (addr_d >> 3);
      tgt_wdata_d = narrow_d ? {56'h0, wdata_d[{beat_d, 3'b000} +: 8]} : wdata_d;
    end

    rsp_valid_d = (state_d == S_RESP);
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      req_sel_q   <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      narrow_q    <= 1'b0;
      beat_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      tgt_en_q    <= '0;
      tgt_we_q    <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      req_sel_q   <= req_sel_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      narrow_q    <= narrow_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      tgt_en_q    <= tgt_en_d;
      tgt_we_q    <= tgt_we_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tgt_en    = tgt_en_q;
  assign tgt_we    = tgt_we_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;

endmodule

// File: tb/tb_backdoor_access_engine.sv
// Directed bench for backdoor_access_engine: three targets (0 and 2 wide,
// 1 byte-wide), behavioural target memories, and a beat log.
module tb_backdoor_access_engine;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sel_set = 1'b0;
  logic [1:0]        sel_value = '0;
  logic [1:0]        sel_q;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic [2:0]        tgt_en;
  logic              tgt_we;
  logic [31:0]       tgt_addr;
  logic [63:0]       tgt_wdata;
  logic [191:0]      tgt_rdata;
  logic [2:0]        tgt_busy = '0;

  backdoor_access_engine #(
    .NUM_TARGETS(3), .ADDR_W(32), .NARROW_MASK(3'b010), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .sel_set(sel_set), .sel_value(sel_value), .sel_q(sel_q),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tgt_en(tgt_en), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
    .tgt_rdata(tgt_rdata), .tgt_busy(tgt_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;

  // Target memories with one-cycle read latency
  logic [63:0] mem_w0 [256];
  logic [63:0] mem_w2 [256];
  logic [7:0]  mem_b1 [256];
  logic [63:0] rd0 = '0, rd1 = '0, rd2 = '0;
  assign tgt_rdata = {rd2, rd1, rd0};

  always @(posedge clk) begin
    if (tgt_en[0]) begin
      if (tgt_we) mem_w0[tgt_addr[7:0]] <= tgt_wdata;
      else        rd0 <= mem_w0[tgt_addr[7:0]];
    end
    if (tgt_en[1]) begin
      if (tgt_we) mem_b1[tgt_addr[7:0]] <= tgt_wdata[7:0];
      else        rd1 <= {56'h0, mem_b1[tgt_addr[7:0]]};
    end
    if (tgt_en[2]) begin
      if (tgt_we) mem_w2[tgt_addr[7:0]] <= tgt_wdata;
      else        rd2 <= mem_w2[tgt_addr[7:0]];
    end
  end

  // Beat log
  int          lg_tgt  [$];
  logic        lg_we   [$];
  logic [31:0] lg_addr [$];
  logic [63:0] lg_data [$];
  int          lg_cyc  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (tgt_en[i]) begin
          lg_tgt.push_back(i);
          lg_we.push_back(tgt_we);
          lg_addr.push_back(tgt_addr);
          lg_data.push_back(tgt_wdata);
          lg_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic log_clear();
    lg_tgt.delete(); lg_we.delete(); lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
  endtask

  // Issue one request (caller is at posedge+#1), wait for the response, consume it
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                        output int lat, output logic [63:0] rd, output logic er);
    log_clear();
    lat = -1; rd = '0; er = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      tests++; fails++;
      $error("FAIL timeout: no rsp_valid for addr %0h within 200 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_sel(input logic [1:0] v);
    sel_set = 1'b1; sel_value = v;
    @(posedge clk); #1;
    sel_set = 1'b0;
  endtask

  int          lat;
  logic [63:0] rd;
  logic        er;
  int          exp_stall [8];
  logic [63:0] stall_data;

  initial begin
    exp_stall = '{1, 2, 3, 9, 10, 11, 12, 13};
    stall_data = 64'hA5C3_0F1E_1234_5678;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst sel_q", 64'(sel_q), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_err", 64'(rsp_err), 64'd0);
    chk("rst rsp_rdata", rsp_rdata, 64'd0);
    chk("rst tgt_en", 64'(tgt_en), 64'd0);
    chk("rst tgt_we", 64'(tgt_we), 64'd0);
    chk("rst tgt_addr", 64'(tgt_addr), 64'd0);
    chk("rst tgt_wdata", tgt_wdata, 64'd0);

    // Wide write / read on target 0
    do_req(1'b1, 32'h1000, 64'h0123_4567_89AB_CDEF, lat, rd, er);
    chk("wide wr lat", 64'(lat), 64'd2);
    chk("wide wr beats", 64'(lg_tgt.size()), 64'd1);
    if (lg_tgt.size() == 1) begin
      chk("wide wr tgt", 64'(lg_tgt[0]), 64'd0);
      chk("wide wr we", 64'(lg_we[0]), 64'd1);
      chk("wide wr addr", 64'(lg_addr[0]), 64'h200);
      chk("wide wr data", lg_data[0], 64'h0123_4567_89AB_CDEF);
    end
    chk("wide wr rdata", rd, 64'd0);
    chk("wide wr err", 64'(er), 64'd0);

    do_req(1'b0, 32'h1000, 64'h0, lat, rd, er);
    chk("wide rd lat", 64'(lat), 64'd3);
    chk("wide rd data", rd, 64'h0123_4567_89AB_CDEF);
    chk("wide rd beats", 64'(lg_tgt.size()), 64'd1);
    if (lg_tgt.size() == 1) begin
      chk("wide rd we", 64'(lg_we[0]), 64'd0);
      chk("wide rd addr", 64'(lg_addr[0]), 64'h200);
    end

    // Narrow write / read on target 1
    set_sel(2'd1);
    chk("sel_q after set", 64'(sel_q), 64'd1);
    do_req(1'b1, 32'h40, 64'h1122_3344_5566_7788, lat, rd, er);
    chk("narrow wr lat", 64'(lat), 64'd9);
    chk("narrow wr beats", 64'(lg_tgt.size()), 64'd8);
    for (int k = 0; k < 8 && k < lg_tgt.size(); k++) begin
      chk("narrow wr tgt", 64'(lg_tgt[k]), 64'd1);
      chk("narrow wr addr", 64'(lg_addr[k]), 64'(32'h40 + k));
      chk("narrow wr byte", lg_data[k], (64'h1122_3344_5566_7788 >> (8*k)) & 64'hFF);
    end

    do_req(1'b0, 32'h40, 64'h0, lat, rd, er);
    chk("narrow rd lat", 64'(lat), 64'd17);
    chk("narrow rd data", rd, 64'h1122_3344_5566_7788);
    chk("narrow rd beats", 64'(lg_tgt.size()), 64'd8);

    // Busy stall before beat 3: busy sampled high at five edges
    fork
      do_req(1'b1, 32'h80, stall_data, lat, rd, er);
      begin
        repeat (3) @(posedge clk);
        #1 tgt_busy[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1 tgt_busy[1] = 1'b0;
      end
    join
    chk("stall lat", 64'(lat), 64'd14);
    chk("stall beats", 64'(lg_tgt.size()), 64'd8);
    for (int k = 0; k < 8 && k < lg_tgt.size(); k++) begin
      chk("stall beat cycle", 64'(lg_cyc[k] - t0), 64'(exp_stall[k]));
      chk("stall beat addr", 64'(lg_addr[k]), 64'(32'h80 + k));
    end

    // Select change during a narrow read keeps the latched target
    fork
      do_req(1'b0, 32'h80, 64'h0, lat, rd, er);
      begin
        repeat (3) @(posedge clk);
        #1 sel_set = 1'b1; sel_value = 2'd0;
        @(posedge clk);
        #1 sel_set = 1'b0;
      end
    join
    chk("midsel lat", 64'(lat), 64'd17);
    chk("midsel data", rd, stall_data);
    chk("midsel beats", 64'(lg_tgt.size()), 64'd8);
    for (int k = 0; k < 8 && k < lg_tgt.size(); k++)
      chk("midsel tgt", 64'(lg_tgt[k]), 64'd1);
    chk("midsel sel_q", 64'(sel_q), 64'd0);
    do_req(1'b0, 32'h1000, 64'h0, lat, rd, er);
    chk("post sel data", rd, 64'h0123_4567_89AB_CDEF);
    chk("post sel beats", 64'(lg_tgt.size()), 64'd1);
    if (lg_tgt.size() == 1) chk("post sel tgt", 64'(lg_tgt[0]), 64'd0);

    // Out-of-range select
    set_sel(2'd3);
    do_req(1'b0, 32'h10, 64'h0, lat, rd, er);
    chk("err lat", 64'(lat), 64'd1);
    chk("err flag", 64'(er), 64'd1);
    chk("err rdata", rd, 64'd0);
    chk("err beats", 64'(lg_tgt.size()), 64'd0);

    // Reset during beat 4 of a narrow write
    set_sel(2'd1);
    log_clear();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC0; req_wdata = 64'hFFEE_DDCC_BBAA_9988;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort beat4 en", 64'(tgt_en), 64'b010);
    chk("abort beat4 addr", 64'(tgt_addr), 64'hC4);
    rst = 1'b1;
    #1;
    chk("abort tgt_en", 64'(tgt_en), 64'd0);
    chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort sel_q", 64'(sel_q), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort req_ready", 64'(req_ready), 64'd1);
    do_req(1'b1, 32'h1008, 64'hDEAD_BEEF_CAFE_F00D, lat, rd, er);
    chk("after abort wr lat", 64'(lat), 64'd2);
    if (lg_tgt.size() == 1) chk("after abort wr addr", 64'(lg_addr[0]), 64'h201);
    else chk("after abort wr beats", 64'(lg_tgt.size()), 64'd1);
    do_req(1'b0, 32'h1008, 64'h0, lat, rd, er);
    chk("after abort rd lat", 64'(lat), 64'd3);
    chk("after abort rd data", rd, 64'hDEAD_BEEF_CAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
